// File: rtl/nios2_dbg_scan_pkg.sv
`default_nettype none
//==============================================================================
// Module : nios2_dbg_scan_pkg
// Brief  : Shared types and constants for the debug-slave scan master.
// Rev    : 1.0 - initial release
//==============================================================================
package nios2_dbg_scan_pkg;

    localparam int DBG_DR_WIDTH = 38;
    localparam int DBG_IR_WIDTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UIR   = 3'd1,
        ST_CDR   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_UDR   = 3'd4,
        ST_RTI   = 3'd5,
        ST_RESP  = 3'd6
    } scan_state_t;

    localparam logic [DBG_IR_WIDTH-1:0] c_IR_OCIMEM   = 2'd0;
    localparam logic [DBG_IR_WIDTH-1:0] c_IR_TRACE    = 2'd1;
    localparam logic [DBG_IR_WIDTH-1:0] c_IR_BREAK    = 2'd2;
    localparam logic [DBG_IR_WIDTH-1:0] c_IR_TRACEMEM = 2'd3;

endpackage
`default_nettype wire

// File: rtl/nios2_dbg_tck_gen.sv
`default_nettype none
//==============================================================================
// Module : nios2_dbg_tck_gen
// Brief  : Divided test clock with single-cycle rise/fall ticks; idles low and
//          restarts phase-aligned whenever enable rises.
// Rev    : 1.0 - initial release
//==============================================================================
module nios2_dbg_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tck,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int c_DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_tck;
    logic               w_wrap;

    // Ticks are asserted in the cycle before the edge that moves tck.
    assign w_wrap    = enable && (r_div_cnt == c_DIV_W'(TCK_DIV - 1));
    assign rise_tick = w_wrap && !r_tck;
    assign fall_tick = w_wrap &&  r_tck;
    assign tck       = r_tck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_tck     <= 1'b0;
        end else if (!enable) begin
            r_div_cnt <= '0;
            r_tck     <= 1'b0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            r_tck     <= !r_tck;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/nios2_debug_slave_scan_master.sv
`default_nettype none
//==============================================================================
// Module : nios2_debug_slave_scan_master
// Brief  : Issues one full virtual-JTAG IR+DR scan per command and returns the
//          captured DR. Option NIOS2_DBG_SCAN_IR_CACHE_EN skips UIR on IR reuse.
// Rev    : 1.0 - initial release
//==============================================================================
module nios2_debug_slave_scan_master
    import nios2_dbg_scan_pkg::*;
#(
    parameter int DR_WIDTH = DBG_DR_WIDTH,
    parameter int IR_WIDTH = DBG_IR_WIDTH,
    parameter int TCK_DIV  = 2,
    parameter int RTI_TCKS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int c_BIT_W = $clog2(DR_WIDTH + 1);

    scan_state_t         r_state;
    scan_state_t         w_next;
    logic                w_accept;
    logic                w_skip_uir;
    logic                w_tck_en;
    logic                w_rise;
    logic                w_fall;
    logic [DR_WIDTH-1:0] r_dr_shift;
    logic [DR_WIDTH-1:0] w_dr_shifted;
    logic [DR_WIDTH-1:0] r_rsp_sr;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [3:0]          r_rti_cnt;
    logic [IR_WIDTH-1:0] r_ir_in;
    logic                r_rsp_valid;
    logic                r_tdi;
    logic                r_uir, r_cdr, r_sdr, r_udr, r_rti;
    logic                w_uir, w_cdr, w_sdr, w_udr, w_rti, w_tdi;

    assign cmd_ready    = (r_state == ST_IDLE) && !r_rsp_valid;
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_tck_en     = (r_state == ST_UIR) || (r_state == ST_CDR) || (r_state == ST_SHIFT) ||
                          (r_state == ST_UDR) || (r_state == ST_RTI);
    assign w_dr_shifted = r_dr_shift >> 1;

    assign rsp_valid = r_rsp_valid;
    assign rsp_dr    = r_rsp_sr;
    assign vji_tdi   = r_tdi;
    assign vji_ir_in = r_ir_in;
    assign vji_uir   = r_uir;
    assign vji_cdr   = r_cdr;
    assign vji_sdr   = r_sdr;
    assign vji_udr   = r_udr;
    assign vji_rti   = r_rti;

`ifdef NIOS2_DBG_SCAN_IR_CACHE_EN
    logic r_ir_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir_valid <= 1'b0;
        end else if (w_accept) begin
            r_ir_valid <= 1'b1;
        end
    end

    assign w_skip_uir = r_ir_valid && (cmd_ir == r_ir_in);
`else
    assign w_skip_uir = 1'b0;
`endif

    nios2_dbg_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (w_tck_en),
        .tck       (vji_tck),
        .rise_tick (w_rise),
        .fall_tick (w_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every scan state advances only on a tck fall, so each lasts whole periods.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = w_skip_uir ? ST_CDR : ST_UIR;
            ST_UIR:   if (w_fall) w_next = ST_CDR;
            ST_CDR:   if (w_fall) w_next = ST_SHIFT;
            ST_SHIFT: if (w_fall && (r_bit_cnt == c_BIT_W'(DR_WIDTH))) w_next = ST_UDR;
            ST_UDR:   if (w_fall) w_next = ST_RTI;
            ST_RTI:   if (w_fall && (r_rti_cnt == 4'(RTI_TCKS))) w_next = ST_RESP;
            ST_RESP:  if (r_rsp_valid && rsp_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase

        w_uir = (w_next == ST_UIR);
        w_cdr = (w_next == ST_CDR);
        w_sdr = (w_next == ST_SHIFT);
        w_udr = (w_next == ST_UDR);
        w_rti = (w_next == ST_RTI);

        w_tdi = 1'b0;
        if (w_next == ST_SHIFT) begin
            w_tdi = ((r_state == ST_SHIFT) && w_fall) ? w_dr_shifted[0] : r_dr_shift[0];
        end
    end

    // rsp_valid trails RESP entry by one cycle and drops on the handshake edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_uir       <= 1'b0;
            r_cdr       <= 1'b0;
            r_sdr       <= 1'b0;
            r_udr       <= 1'b0;
            r_rti       <= 1'b0;
            r_tdi       <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_uir       <= w_uir;
            r_cdr       <= w_cdr;
            r_sdr       <= w_sdr;
            r_udr       <= w_udr;
            r_rti       <= w_rti;
            r_tdi       <= w_tdi;
            r_rsp_valid <= (r_state == ST_RESP) && !(r_rsp_valid && rsp_ready);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dr_shift <= '0;
            r_rsp_sr   <= '0;
            r_bit_cnt  <= '0;
            r_rti_cnt  <= '0;
            r_ir_in    <= '0;
        end else if (w_accept) begin
            r_dr_shift <= cmd_dr;
            r_rsp_sr   <= '0;
            r_bit_cnt  <= '0;
            r_rti_cnt  <= '0;
            if (!w_skip_uir) begin
                r_ir_in <= cmd_ir;
            end
        end else begin
            if ((r_state == ST_SHIFT) && w_rise) begin
                r_rsp_sr  <= {vji_tdo, r_rsp_sr[DR_WIDTH-1:1]};
                r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
            end
            if ((r_state == ST_SHIFT) && w_fall) begin
                r_dr_shift <= w_dr_shifted;
            end
            if ((r_state == ST_RTI) && w_rise) begin
                r_rti_cnt <= r_rti_cnt + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/nios2_debug_slave_scan_master.md
Name: nios2_debug_slave_scan_master

Overview:
- Initiator side of the 2-bit-IR virtual-JTAG debug-slave protocol.
- Drives tck, tdi, ir_in and the uir/cdr/sdr/udr/rti state strobes into the CPU debug-slave tck/sysclk pair, and collects tdo.
- Lets an on-chip debug agent or testbench issue IR+DR scans without a physical JTAG hub.
- Each command is one full scan (UIR, CDR, SHIFT, UDR, RTI) and returns the captured DR.

Parameters:
- DR_WIDTH, 38, scan data register length in bits.
- IR_WIDTH, 2, virtual instruction width.
- TCK_DIV, 2, tck half-period in clk cycles; legal range 1..255.
- RTI_TCKS, 2, tck periods spent in run-test-idle after UDR; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  scan request.
- cmd_ready  out  1  master idle, command can be accepted.
- cmd_ir  in  IR_WIDTH  instruction to load.
- cmd_dr  in  DR_WIDTH  data to shift in, LSB first.
- rsp_valid  out  1  scan complete.
- rsp_ready  in  1  response consumed.
- rsp_dr  out  DR_WIDTH  data captured from tdo, bit0 = first bit shifted out.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_ir_in  out  IR_WIDTH  virtual IR value.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state strobes.

Behaviour:
- Reset and idle:
  - Reset asserted (async, any time, including mid-scan): FSM to IDLE, all outputs 0 except cmd_ready=1, tck divider and bit counter cleared.
  - tck is held low when not scanning.
- Accept and response handshake:
  - A command is accepted on the clk edge where cmd_valid & cmd_ready; cmd_ir and cmd_dr are latched, cmd_ready drops the next cycle.
  - cmd_ready=1 only in IDLE with no pending response.
- tck generation:
  - While busy, tck toggles every TCK_DIV clk cycles, starting low; one tck period = 2*TCK_DIV clk.
  - Each state below lasts a whole number of tck periods. Strobes and tdi change only on the clk edge that makes tck fall; tdo is sampled on the edge that makes tck rise.
- FSM: IDLE -> UIR -> CDR -> SHIFT -> UDR -> RTI -> RESP -> IDLE.
  - UIR: 1 period. vji_ir_in = latched IR, vji_uir=1. vji_ir_in then holds its value until the next UIR.
  - CDR: 1 period, vji_cdr=1.
  - SHIFT: DR_WIDTH periods, vji_sdr=1.
    - tdi = dr_shift[0] throughout each period.
    - On the tck rise, tdo is shifted into rsp bit DR_WIDTH-1 (right shift); dr_shift shifts right on the following fall.
    - The bit counter is ceil(log2(DR_WIDTH+1)) wide and exits SHIFT when it reaches DR_WIDTH.
  - UDR: 1 period, vji_udr=1.
  - RTI: RTI_TCKS periods, vji_rti=1.
  - RESP: tck low, rsp_valid=1 with rsp_dr stable until rsp_ready. IDLE is entered the cycle after the handshake.
- Latency:
  - rsp_valid rises exactly 2*TCK_DIV*(DR_WIDTH+3+RTI_TCKS)+1 clk cycles after the accepting edge.
  - Defaults: 2*2*(38+3+2)+1 = 173 cycles.
- Boundaries:
  - rsp_ready held high through RESP: single-cycle rsp_valid.
  - cmd_valid asserted during a scan is ignored (not queued).
  - Exactly one strobe is high at any instant; none in IDLE/RESP.
  - cmd_dr/cmd_ir changes after acceptance have no effect.

Optional Feature:
- Macro: NIOS2_DBG_SCAN_IR_CACHE_EN.
- Defined:
  - A valid-IR register holds the last loaded IR; it is cleared by reset.
  - If a new command's cmd_ir equals the cached IR and the cache is valid, the UIR state is skipped (IDLE -> CDR). Latency is reduced by 2*TCK_DIV cycles.
- Undefined: UIR occurs on every command; no cache register is present.

Decomposition:
- Package nios2_dbg_scan_pkg holds:
  - the FSM state enum (IDLE, UIR, CDR, SHIFT, UDR, RTI, RESP);
  - default constants DBG_DR_WIDTH=38, DBG_IR_WIDTH=2;
  - named IR codes: 0 = ocimem, 1 = trace, 2 = break, 3 = tracemem.
- One sub-module is natural: nios2_dbg_tck_gen.
  - Parameterised by TCK_DIV; enable input.
  - Outputs tck, rise_tick and fall_tick (single-clk pulses aligned to the tck edges).
  - Idles low and restarts phase-aligned when enable rises.

Test Plan:
- Reset/idle: reset_n=0 mid-SHIFT (bit 17) -> all strobes, tck, rsp_valid = 0 immediately; cmd_ready=1 after release. A following scan completes correctly.
- Loopback (vji_tdo tied to vji_tdi via 1-tck delay model of slave sr): cmd_ir=2'b10, cmd_dr=38'h2A_5A5A_5A5A. Expect:
  - vji_ir_in=2 during UIR;
  - rsp_dr equal to cmd_dr;
  - rsp_valid at accept+173 cycles (defaults).
- Strobe order/width (TCK_DIV=3): uir 6 clk, cdr 6 clk, sdr 228 clk, udr 6 clk, rti 12 clk; no overlap; tdi stable across every tck rise.
- Backpressure: rsp_ready=0 for 50 cycles -> rsp_valid and rsp_dr held, cmd_ready=0. Then rsp_ready=1 -> cmd_ready=1 next cycle. A cmd_valid pulse during the scan is dropped.
- Slave-driven tdo pattern: tdo = alternating 1,0 starting 1 -> rsp_dr=38'h15_5555_5555.
- With NIOS2_DBG_SCAN_IR_CACHE_EN: two back-to-back cmd_ir=1 -> second scan has no vji_uir pulse and completes 4 cycles sooner (169). Then cmd_ir=3 -> uir present.
